csi_pkt_sequencer: RTL

CSI_PKT_SEQUENCER -- requirements
Module: csi_pkt_sequencer

---
 rtl/csi_pkt_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/csi_pkt_sequencer.sv
// csi_pkt_sequencer: CSI-2 packet parser that feeds RAW10 payload words of the selected VC to a decoder.
// Ports: rxbyteclkhs/reset (sync, active-high); data_in[15:0] + data_in_valid (lane-merged bytes, [7:0] first);
//        payload_out/frame_active/line_start to the decoder; frame_valid/frame_start/frame_end framing;
//        line_count/frame_count counters; pkt_abort (gap truncation) and wc_err (word count rejected) pulses.
// Optional: define CSIRX_WC_CHECK_EN to reject RAW10 packets whose word count is not a multiple of 10.
module csi_pkt_sequencer #(
   parameter logic [1:0] VC_ID    = 2'd0,
   parameter logic [5:0] RAW10_DT = 6'h2B
) (
   input  logic        rxbyteclkhs,
   input  logic        reset,
   input  logic [15:0] data_in,
   input  logic        data_in_valid,
   output logic [15:0] payload_out,
   output logic        frame_active,
   output logic        frame_valid,
   output logic        frame_start,
   output logic        frame_end,
   output logic        line_start,
   output logic [15:0] line_count,
   output logic [15:0] frame_count,
   output logic        pkt_abort,
   output logic        wc_err
);
   typedef enum logic [2:0] {IDLE, HDR2, PAYLOAD, SKIP, CRC} state_t;
   state_t state_q, state_d;
   logic [7:0] di_q, wc_lo_q;
   logic [15:0] cnt_q, cnt_d, payload_q, payload_d, lc_q, lc_d, fc_q, fc_d;
   logic raw_q, raw_d, first_q, first_d, fa_q, fa_d, fv_q, fv_d;
   logic fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, ab_q, ab_d, we_q, we_d;
   logic [15:0] wc, words;
   logic [5:0] dt;
   logic is_raw, wc_bad, accept;
   assign wc = {data_in[7:0], wc_lo_q};
   assign dt = di_q[5:0];
   assign is_raw = dt == RAW10_DT && di_q[7:6] == VC_ID && fv_q;
`ifdef CSIRX_WC_CHECK_EN
   assign wc_bad = (wc % 16'd10) != 16'd0;
`else
   assign wc_bad = 1'b0;
`endif
   assign accept = is_raw && !wc_bad && wc != 16'd0;
   // word count is in bytes, two bytes per word, rounded up
   assign words = 16'((17'(wc) + 17'd1) >> 1);
   assign payload_out = payload_q;
   assign frame_active = fa_q;
   assign frame_valid = fv_q;
   assign frame_start = fs_q;
   assign frame_end = fe_q;
   assign line_start = ls_q;
   assign line_count = lc_q;
   assign frame_count = fc_q;
   assign pkt_abort = ab_q;
   assign wc_err = we_q;
   always_ff @(posedge rxbyteclkhs) begin
      if (reset) begin
         state_q <= IDLE;
         di_q <= '0;
         wc_lo_q <= '0;
         cnt_q <= '0;
         raw_q <= 1'b0;
         first_q <= 1'b0;
         payload_q <= '0;
         fa_q <= 1'b0;
         fv_q <= 1'b0;
         fs_q <= 1'b0;
         fe_q <= 1'b0;
         ls_q <= 1'b0;
         lc_q <= '0;
         fc_q <= '0;
         ab_q <= 1'b0;
         we_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && data_in_valid) begin
            di_q <= data_in[7:0];
            wc_lo_q <= data_in[15:8];
         end
         cnt_q <= cnt_d;
         raw_q <= raw_d;
         first_q <= first_d;
         payload_q <= payload_d;
         fa_q <= fa_d;
         fv_q <= fv_d;
         fs_q <= fs_d;
         fe_q <= fe_d;
         ls_q <= ls_d;
         lc_q <= lc_d;
         fc_q <= fc_d;
         ab_q <= ab_d;
         we_q <= we_d;
      end
   end
   always_comb begin
      state_d = state_q;
      if (!data_in_valid) state_d = IDLE;
      else case (state_q)
         IDLE:          state_d = HDR2;
         HDR2:          state_d = dt < 6'h10 ? IDLE : wc == 16'd0 ? CRC : accept ? PAYLOAD : SKIP;
         PAYLOAD, SKIP: state_d = cnt_q == 16'd1 ? CRC : state_q;
         default:       state_d = IDLE;
      endcase
   end
   always_comb begin
      cnt_d = cnt_q;
      raw_d = raw_q;
      first_d = first_q;
      payload_d = '0;
      fa_d = 1'b0;
      fv_d = fv_q;
      fs_d = 1'b0;
      fe_d = 1'b0;
      ls_d = 1'b0;
      lc_d = lc_q;
      fc_d = fc_q;
      ab_d = 1'b0;
      we_d = 1'b0;
      if (!data_in_valid) ab_d = state_q != IDLE;
      else case (state_q)
         HDR2: begin
            cnt_d = words;
            raw_d = accept;
            first_d = 1'b1;
            we_d = dt >= 6'h10 && is_raw && wc_bad;
            if (dt == 6'h00) begin
               fv_d = 1'b1;
               fs_d = 1'b1;
               lc_d = '0;
               fc_d = fc_q + 16'd1;
            end else if (dt == 6'h01 && fv_q) begin
               fv_d = 1'b0;
               fe_d = 1'b1;
            end
         end
         PAYLOAD: begin
            payload_d = data_in;
            fa_d = 1'b1;
            ls_d = first_q;
            first_d = 1'b0;
            cnt_d = cnt_q - 16'd1;
         end
         SKIP: cnt_d = cnt_q - 16'd1;
         CRC: lc_d = raw_q && lc_q != 16'hFFFF ? lc_q + 16'd1 : lc_q;
         default: ;
      endcase
   end
endmodule
